fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, SHALL set the entry count; power of two, >= 4.
REQ-002 Parameter AFULL_THRESH, default FIFO_DEPTH-2, SHALL set the almost_full level; range 1..FIFO_DEPTH.
REQ-003 Derived width AW = $clog2(FIFO_DEPTH)+1 SHALL be used for all pointers and level.
REQ-004 clk  input  1  write-domain clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_tvalid  input  1  AXIS slave valid from upstream producer.
REQ-007 s_tready  output  1  AXIS slave ready to upstream producer.
REQ-008 wr_en  output  1  storage-array write strobe.
REQ-009 wr_addr  output  AW-1  storage-array write address.
REQ-010 wr_ptr_gray  output  AW  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-011 rd_ptr_gray_sync  input  AW  Gray read pointer, already synchronized into clk domain.
REQ-012 full  output  1  FIFO full, registered.
REQ-013 almost_full  output  1  level >= AFULL_THRESH, registered.
REQ-014 wr_level  output  AW  conservative fill level, 0..FIFO_DEPTH, registered.

Function
REQ-015 Internal ready_q SHALL reset to 0 and set to 1 on the first clk edge after rst_n deasserts.
REQ-016 s_tready SHALL equal ready_q AND NOT full (combinational from registers only).
REQ-017 A write SHALL occur on a cycle with s_tvalid=1 and s_tready=1; wr_en SHALL equal s_tvalid AND s_tready.
REQ-018 wr_addr SHALL equal wr_ptr_bin[AW-2:0] (current pointer, no added latency).
REQ-019 wr_ptr_bin (AW bits) SHALL increment by 1 modulo 2^AW on each write edge, else hold.
REQ-020 bin_next = wr_ptr_bin + write; gray_next = bin_next XOR (bin_next >> 1).
REQ-021 wr_ptr_gray SHALL be loaded with gray_next every edge; successive values SHALL differ in at most one bit.
REQ-022 full SHALL register (gray_next == {~rd_ptr_gray_sync[AW-1:AW-2], rd_ptr_gray_sync[AW-3:0]}).
REQ-023 rd_bin SHALL be the combinational Gray-to-binary conversion of rd_ptr_gray_sync.
REQ-024 wr_level SHALL register (bin_next - rd_bin) modulo 2^AW; almost_full SHALL register (that value >= AFULL_THRESH).
REQ-025 Write attempt while full: no write; wr_en=0; pointers, level and full unchanged.
REQ-026 Wrap-around: after 2*FIFO_DEPTH writes, wr_ptr_bin and wr_ptr_gray SHALL return to 0 with no glitch on full.
REQ-027 Read-side advance while full: full SHALL deassert on the edge after rd_ptr_gray_sync changes; s_tready rises in that cycle.
REQ-028 Write and read-pointer change in the same cycle: level SHALL reflect both, net unchanged; full/almost_full recomputed from both.
REQ-029 wr_level SHALL never understate occupancy; overstatement due to synchronizer latency is permitted.

Reset
REQ-030 On rst_n=0, asynchronously: wr_ptr_bin=0, wr_ptr_gray=0, full=0, almost_full=0, wr_level=0, ready_q=0 (so s_tready=0, wr_en=0).
REQ-031 Reset asserted mid-burst SHALL abort the burst; no wr_en pulse SHALL occur while rst_n=0 or on the release edge.

Verification (FIFO_DEPTH=16, AFULL_THRESH=14)
REQ-032 Reset release, s_tvalid=1, rd_ptr_gray_sync=0 -> s_tready=0 until first edge, then 16 writes at wr_addr 0..15; full=1 after 16th; wr_level=16; almost_full=1 after 14th.
REQ-033 Full, s_tvalid held 1 for 5 cycles -> wr_en=0, wr_ptr_gray constant 5'b11000.
REQ-034 Full, rd_ptr_gray_sync 0 -> 1 -> full=0 and wr_level=15 on next edge; one write accepted, full=1 again.
REQ-035 Continuous write/read with read pointer tracking write by 3 for 40 writes -> wr_ptr_gray single-bit transitions only, wraps 31->0, wr_level constant 3, full never 1.
REQ-036 rst_n pulsed low at wr_ptr_bin=9 -> all outputs 0 immediately; after release, first wr_addr=0.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side port bundle of an async FIFO: upstream AXIS handshake, storage write port and
// the pointer/status signals exchanged with the read domain.
interface fifo_wr_ctrl_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH) + 1;

  logic          s_tvalid;
  logic          s_tready;
  logic          wr_en;
  logic [AW-2:0] wr_addr;
  logic [AW-1:0] wr_ptr_gray;
  logic [AW-1:0] rd_ptr_gray_sync;
  logic          full;
  logic          almost_full;
  logic [AW-1:0] wr_level;

  // Environment side: producer, storage array and read-domain synchronizer.
  modport master (
    output s_tvalid,
    output rd_ptr_gray_sync,
    input  s_tready,
    input  wr_en,
    input  wr_addr,
    input  wr_ptr_gray,
    input  full,
    input  almost_full,
    input  wr_level
  );

  // Controller side.
  modport slave (
    input  s_tvalid,
    input  rd_ptr_gray_sync,
    output s_tready,
    output wr_en,
    output wr_addr,
    output wr_ptr_gray,
    output full,
    output almost_full,
    output wr_level
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of an async FIFO: accepts AXIS beats, advances binary/Gray write
// pointers and derives registered full, almost_full and a conservative fill level.
module fifo_wr_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AFULL_THRESH = FIFO_DEPTH - 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_wr_ctrl_if.slave  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] AfullLevel = AW'(AFULL_THRESH);

  logic          ready_q;
  logic [AW-1:0] wr_ptr_bin_q, wr_ptr_bin_d;
  logic [AW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [AW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic [AW-1:0] rd_bin;
  logic          s_tready;
  logic          write;

  assign s_tready = ready_q & ~full_q;
  assign write    = bus.s_tvalid & s_tready;

  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < int'(AW); i++) begin
      rd_bin[i] = ^(bus.rd_ptr_gray_sync >> i);
    end
  end

  always_comb begin
    wr_ptr_bin_d  = wr_ptr_bin_q + AW'(write);
    wr_ptr_gray_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
    // Full when write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_d  = (wr_ptr_gray_d == {~bus.rd_ptr_gray_sync[AW-1:AW-2],
                                 bus.rd_ptr_gray_sync[AW-3:0]});
    level_d = wr_ptr_bin_d - rd_bin;
    afull_d = (level_d >= AfullLevel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q       <= 1'b0;
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
    end else begin
      ready_q       <= 1'b1;
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      level_q       <= level_d;
      full_q        <= full_d;
      afull_q       <= afull_d;
    end
  end

  assign bus.s_tready    = s_tready;
  assign bus.wr_en       = write;
  assign bus.wr_addr     = wr_ptr_bin_q[AW-2:0];
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wr_level    = level_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic, checked against a model
// that tracks total writes and reads as plain counters.
module tb_fifo_wr_ctrl;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 14;
  localparam int unsigned AW     = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  fifo_wr_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .AFULL_THRESH(THRESH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: counts of beats written / read since reset, and registered status.
  int unsigned m_wcnt, m_rcnt, m_level;
  bit          m_ready, m_full, m_afull;

  function automatic logic [AW-1:0] to_gray(input int unsigned n);
    logic [AW-1:0] b;
    b = AW'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_ready;
    exp_ready = m_ready && !m_full;
    check_eq("s_tready", 32'(bus.s_tready), 32'(exp_ready));
    check_eq("wr_en", 32'(bus.wr_en), 32'(bus.s_tvalid && exp_ready));
    check_eq("wr_addr", 32'(bus.wr_addr), m_wcnt % DEPTH);
    check_eq("wr_ptr_gray", 32'(bus.wr_ptr_gray), 32'(to_gray(m_wcnt)));
    check_eq("full", 32'(bus.full), 32'(m_full));
    check_eq("almost_full", 32'(bus.almost_full), 32'(m_afull));
    check_eq("wr_level", 32'(bus.wr_level), m_level);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_tready"}, 32'(bus.s_tready), 0);
    check_eq({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    check_eq({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    check_eq({tag, "_gray"}, 32'(bus.wr_ptr_gray), 0);
    check_eq({tag, "_full"}, 32'(bus.full), 0);
    check_eq({tag, "_afull"}, 32'(bus.almost_full), 0);
    check_eq({tag, "_level"}, 32'(bus.wr_level), 0);
  endtask

  // One clock: drive read pointer, check at negedge, update model at posedge.
  task automatic step();
    bit wr;
    bus.rd_ptr_gray_sync = to_gray(m_rcnt);
    @(negedge clk);
    check_outputs();
    wr = bus.s_tvalid && m_ready && !m_full;
    @(posedge clk);
    if (wr) m_wcnt++;
    m_ready = 1'b1;
    m_level = (m_wcnt - m_rcnt) % (2 * DEPTH);
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= THRESH);
    #1;
  endtask

  task automatic model_reset();
    m_wcnt  = 0;
    m_rcnt  = 0;
    m_level = 0;
    m_ready = 1'b0;
    m_full  = 1'b0;
    m_afull = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] prev_gray;
    int unsigned   guard;
    model_reset();
    bus.s_tvalid         = 1'b1;
    bus.rd_ptr_gray_sync = '0;
    #1;
    check_all_zero("reset");

    // Fill from empty with valid held high across reset release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) step();
    check_eq("fill_full", 32'(bus.full), 1);
    check_eq("fill_level", 32'(bus.wr_level), 16);
    check_eq("fill_afull", 32'(bus.almost_full), 1);
    check_eq("fill_gray", 32'(bus.wr_ptr_gray), 32'h18);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_gray", 32'(bus.wr_ptr_gray), 32'h18);
    end

    // One read frees one slot; the next beat refills it.
    m_rcnt = 1;
    step();
    check_eq("drain_full", 32'(bus.full), 0);
    check_eq("drain_level", 32'(bus.wr_level), 15);
    step();
    check_eq("refill_full", 32'(bus.full), 1);

    // Random traffic; read side never passes the write side.
    for (int i = 0; i < 400; i++) begin
      bus.s_tvalid = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && m_rcnt < m_wcnt) m_rcnt++;
      step();
    end

    // Reset pulse mid-burst at write pointer 9.
    rst_n = 1'b0;
    model_reset();
    bus.rd_ptr_gray_sync = '0;
    #1;
    check_all_zero("rst1");
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.s_tvalid = 1'b1;
    guard        = 0;
    while (m_wcnt != 9 && guard < 20) begin
      step();
      guard++;
    end
    check_eq("reach_ptr9", m_wcnt, 9);
    #2;
    rst_n = 1'b0;
    model_reset();
    bus.rd_ptr_gray_sync = '0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;

    // Read pointer trails the writer so the level settles at 3 across a wrap.
    for (int i = 0; i < 45; i++) begin
      prev_gray = bus.wr_ptr_gray;
      step();
      if (m_wcnt >= 2) m_rcnt = m_wcnt - 2;
      check_eq("gray_1bit", 32'($countones(bus.wr_ptr_gray ^ prev_gray) <= 1), 1);
      check_eq("track_full", 32'(bus.full), 0);
      if (m_wcnt >= 3) check_eq("track_level", 32'(bus.wr_level), 3);
      if (m_wcnt == 32) check_eq("wrap_gray", 32'(bus.wr_ptr_gray), 0);
    end
    check_eq("track_writes", 32'(m_wcnt > 32), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
